sram_controller: RTL and testbench
==================================

// Module: sram_controller
//
// PURPOSE
// Sequences MEM-stage loads/stores onto the external 64-bit-wide SRAM (17-bit word
// address, shared inout dq, active-low we_n, 30 ns read access). Latches one request,
// holds SRAM signals stable for a fixed wait window, returns the selected 32-bit word.
// Deasserts ready while an access is pending; the hazard/freeze logic stalls the pipeline on ~ready.
//
// PARAMETERS
// WAIT_CYCLES  5     clocks SRAM signals are held per access (covers 30 ns at 50 MHz); >=1
// ADDR_BASE    1024  byte address mapped to SRAM word 0
// ADDR_W       17    SRAM word-address width
//
// PORTS
// clk         in     1   system clock, all state on posedge
// rst         in     1   synchronous, active-high reset
// rd_en       in     1   MEM-stage load request (level)
// wr_en       in     1   MEM-stage store request (level)
// address     in     32  byte address from ALU
// write_data  in     32  store data
// read_data   out    32  load result, registered
// ready       out    1   1 = no pending access / access complete this cycle
// SRAM_addr   out    17  SRAM word address
// SRAM_we_n   out    1   SRAM write enable, active low
// SRAM_dq     inout  64  SRAM data bus
//
// BEHAVIOUR
// - States: IDLE, ACCESS, DONE. Reset (sync, overrides all): state=IDLE, cnt=0,
//   read_data=0, SRAM_we_n=1, SRAM_addr=0, SRAM_dq released (z).
// - IDLE: if wr_en|rd_en, latch op (wr_en wins if both high), address-ADDR_BASE, write_data;
//   cnt<=0; go ACCESS. Otherwise stay.
// - ACCESS: cnt counts 0..WAIT_CYCLES-1; at cnt==WAIT_CYCLES-1 go DONE. On a read, load
//   read_data from dq in that last ACCESS cycle.
// - DONE: unconditional return to IDLE next cycle.
// - ready (combinational) = (IDLE & ~rd_en & ~wr_en) | DONE. Low in IDLE the same cycle a
//   request appears, so the pipeline freezes immediately.
// - Latency: request seen in cycle 0 -> ACCESS cycles 1..W -> DONE (ready=1) in cycle W+1.
//   Back-to-back requests each cost W+2 cycles. No request is accepted in DONE.
// - Address: off = latched address - ADDR_BASE (32-bit, wraps); SRAM_addr = off[ADDR_W+1:2],
//   driven from latched value throughout ACCESS; out-of-range bits are truncated.
// - Read: dq returns {mem[odd], mem[even]} of the pair; read_data = off[2] ? dq[63:32]
//   : dq[31:0]. SRAM_we_n=1, dq tri-stated by controller.
// - Write: SRAM_we_n=0 for every ACCESS cycle (repeated identical writes harmless),
//   SRAM_dq = {32'b0, latched write_data}; SRAM_we_n=1 and dq=z in IDLE/DONE. read_data unchanged.
// - Inputs changing or dropping during ACCESS/DONE are ignored; latched request completes.
// - Reset mid-access aborts: we_n forced 1 on the reset edge, no further SRAM write.
// - dq never driven by controller while SRAM_we_n=1 (no bus contention).
//
// STRUCTURE
// - defines.v: state encodings (IDLE/ACCESS/DONE), default WAIT_CYCLES, data base address,
//   SRAM address/data widths.
// - Single module; wait counter inline (no sub-module needed).
//
// TESTING (bench instantiates SRAM model, clk 20 ns)
// - Reset: hold rst 2 cycles -> ready=1, SRAM_we_n=1, read_data=0, dq=z.
// - Store 0xDEADBEEF to 1024, then load 1024 -> read_data=0xDEADBEEF; ready low 6 cycles,
//   high in 7th (W=5) for each access.
// - Odd word: store 0x11111111 @1024, 0x22222222 @1028; load 1028 -> 0x22222222, load 1024 -> 0x11111111.
// - rd_en&wr_en together @1032 with data 0xA5A5A5A5 -> performs write; later load -> 0xA5A5A5A5.
// - Drop wr_en / change address after cycle 1 -> original address/data written, no second access.
// - Assert rst in 3rd ACCESS cycle of a store -> IDLE, we_n=1 next edge, ready=1, dq=z.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
// Contents:
//   state_t        controller FSM states (IDLE, ACCESS, DONE)
//   DEF_*          default wait window, data base address and SRAM address width
//   DATA_W         CPU word width
//   SRAM_DATA_W    SRAM data bus width (one even/odd word pair)
//   select_word    picks the addressed 32-bit word out of a 64-bit pair
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int          DEF_WAIT_CYCLES = 5;
    localparam logic [31:0] DEF_ADDR_BASE   = 32'd1024;
    localparam int          DEF_ADDR_W      = 17;
    localparam int          DATA_W          = 32;
    localparam int          SRAM_DATA_W     = 64;

    // The SRAM returns {odd word, even word}; bit 2 of the byte offset chooses.
    function automatic logic [DATA_W-1:0] select_word(input logic [SRAM_DATA_W-1:0] pair,
                                                      input logic                   hi);
        return hi ? pair[SRAM_DATA_W-1:DATA_W] : pair[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side request/response bundle of the SRAM controller.
// Signals:
//   rd_en       load request (level)
//   wr_en       store request (level)
//   address     byte address from the ALU
//   write_data  store data
//   read_data   load result
//   ready       1 = no pending access, or the access completes this cycle
// Modports:
//   master      MEM stage / pipeline side
//   slave       controller side
interface sram_controller_if;
    import sram_controller_pkg::*;

    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              ready;

    modport master (
        output rd_en,
        output wr_en,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  rd_en,
        input  wr_en,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );

endinterface

// File: rtl/sram_controller.sv
// Sequences MEM-stage loads and stores onto an external 64-bit-wide SRAM.
// One request is latched in IDLE, the SRAM address/data/we_n are held stable for
// WAIT_CYCLES clocks in ACCESS, and the access is reported complete in DONE.
// ready drops in the same cycle a request appears so the pipeline freezes at once.
// Ports:
//   clk        system clock, all state on posedge
//   rst        synchronous, active-high reset
//   bus        pipeline request/response bundle (slave side)
//   SRAM_addr  SRAM word address, registered
//   SRAM_we_n  SRAM write enable, active low, registered
//   SRAM_dq    SRAM data bus, driven only while SRAM_we_n is low
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [31:0] ADDR_BASE   = DEF_ADDR_BASE,
    parameter int          ADDR_W      = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_controller_if.slave       bus,
    output logic [ADDR_W-1:0]      SRAM_addr,
    output logic                   SRAM_we_n,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_dq
);

    // Counter wide enough for 0..WAIT_CYCLES-1 even when WAIT_CYCLES is 1.
    localparam int              CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              op_write;
    logic              sel_hi;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] read_data_q;

    logic [DATA_W-1:0] req_off;
    logic              req_any;
    logic              unused_off_bits;

    // Offset wraps modulo 2^32; only the word index and pair-select bits matter.
    assign req_off         = bus.address - ADDR_BASE;
    assign req_any         = bus.rd_en | bus.wr_en;
    assign unused_off_bits = ^{req_off[DATA_W-1:ADDR_W+2], req_off[1:0]};

    assign bus.read_data = read_data_q;
    assign bus.ready     = ((state == IDLE) && !req_any) || (state == DONE);

    // Tying the bus driver to the registered we_n makes contention impossible.
    assign SRAM_dq = SRAM_we_n ? {SRAM_DATA_W{1'bz}} : {{(SRAM_DATA_W-DATA_W){1'b0}}, wdata_q};

    // Controller FSM. we_n goes low on the accepting edge of a store and returns
    // high on the edge that enters DONE, so it is low for exactly the ACCESS cycles.
    // A load samples the bus in the last ACCESS cycle, after the full wait window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_write    <= 1'b0;
            sel_hi      <= 1'b0;
            wdata_q     <= '0;
            read_data_q <= '0;
            SRAM_addr   <= '0;
            SRAM_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        op_write  <= bus.wr_en;
                        sel_hi    <= req_off[2];
                        wdata_q   <= bus.write_data;
                        SRAM_addr <= req_off[ADDR_W+1:2];
                        SRAM_we_n <= ~bus.wr_en;
                        cnt       <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == LAST_CNT) begin
                        SRAM_we_n <= 1'b1;
                        state     <= DONE;
                        if (!op_write) begin
                            read_data_q <= select_word(SRAM_dq, sel_hi);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    SRAM_we_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural SRAM model.
// Stimulus pushes the expected completion (read_data, word address, store or load)
// into a queue; a monitor on the falling edge measures each access and compares.
module tb_sram_controller;
    import sram_controller_pkg::*;

    localparam int W = 5;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
        logic [16:0] addr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [16:0] sram_addr;
    logic        sram_we_n;
    wire  [63:0] sram_dq;
    logic [63:0] model_pair;

    sram_controller_if bus ();

    sram_controller #(
        .WAIT_CYCLES(W),
        .ADDR_BASE  (32'd1024),
        .ADDR_W     (17)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .SRAM_addr(sram_addr),
        .SRAM_we_n(sram_we_n),
        .SRAM_dq  (sram_dq)
    );

    // Clock: 20 ns period
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // SRAM model: 32-bit words, reads return the {odd, even} pair, writes store dq[31:0]
    logic [31:0] mem [0:(1<<17)-1];
    initial begin
        for (int i = 0; i < (1 << 17); i++) mem[i] = 32'h0;
    end
    assign model_pair = {mem[{sram_addr[16:1], 1'b1}], mem[{sram_addr[16:1], 1'b0}]};
    assign sram_dq    = sram_we_n ? model_pair : {64{1'bz}};
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr] <= sram_dq[31:0];
    end

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   contention = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: counts ready-low cycles and we_n-low cycles of each access and
    // checks the completion against the scoreboard when ready returns high.
    initial begin
        int          low_cnt;
        int          we_low;
        logic [16:0] last_addr;
        exp_t        e;
        low_cnt   = 0;
        we_low    = 0;
        last_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                low_cnt = 0;
                we_low  = 0;
            end else begin
                if (sram_we_n && (sram_dq !== model_pair)) contention++;
                if (!bus.ready) begin
                    low_cnt++;
                    if (!sram_we_n) we_low++;
                    last_addr = sram_addr;
                end else if (low_cnt > 0) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_access", 64'(low_cnt), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("latency_low_cycles", 64'(low_cnt), 64'(W + 1));
                        checkOutput("we_n_low_cycles", 64'(we_low), e.is_read ? 64'd0 : 64'(W));
                        checkOutput("sram_word_addr", 64'(last_addr), 64'(e.addr));
                        checkOutput(e.is_read ? "load_read_data" : "store_read_data_kept",
                                    64'(bus.read_data), 64'(e.data));
                    end
                    low_cnt = 0;
                    we_low  = 0;
                end
            end
        end
    end

    // Issue one request right after a rising edge and hold it until ready.
    // mutate drops the request and alters address/data once it has been accepted.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [16:0] exp_addr,
                                 input logic [31:0] exp_data, input logic mutate);
        exp_t e;
        int   guard;
        e.is_read = rd & ~wr;
        e.data    = exp_data;
        e.addr    = exp_addr;
        exp_q.push_back(e);
        bus.rd_en      = rd;
        bus.wr_en      = wr;
        bus.address    = addr;
        bus.write_data = data;
        if (mutate) begin
            @(posedge clk);
            #1;
            bus.rd_en      = 1'b0;
            bus.wr_en      = 1'b0;
            bus.address    = addr + 32'd4;
            bus.write_data = ~data;
        end
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.ready && guard < 20);
        if (!bus.ready) checkOutput("ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.address    = 32'd0;
        bus.write_data = 32'd0;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready", 64'(bus.ready), 64'd1);
        checkOutput("reset_we_n", 64'(sram_we_n), 64'd1);
        checkOutput("reset_read_data", 64'(bus.read_data), 64'd0);
        checkOutput("reset_dq_released", sram_dq, 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] store/load at base address");
        applyStimulus(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 17'd0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0,       17'd0, 32'hDEADBEEF, 1'b0);

        $display("[TB] even/odd word select");
        applyStimulus(1'b0, 1'b1, 32'd1024, 32'h11111111, 17'd0, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'd1028, 32'h22222222, 17'd1, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0,        17'd1, 32'h22222222, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0,        17'd0, 32'h11111111, 1'b0);

        $display("[TB] rd_en and wr_en together");
        applyStimulus(1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 17'd2, 32'h11111111, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0,        17'd2, 32'hA5A5A5A5, 1'b0);

        $display("[TB] inputs change after acceptance");
        applyStimulus(1'b0, 1'b1, 32'd1040, 32'h5A5A0001, 17'd4, 32'hA5A5A5A5, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("no_second_access_ready", 64'(bus.ready), 64'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 32'd1044, 32'h0, 17'd5, 32'h00000000, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd1040, 32'h0, 17'd4, 32'h5A5A0001, 1'b0);

        $display("[TB] reset during a store");
        bus.wr_en      = 1'b1;
        bus.address    = 32'd1048;
        bus.write_data = 32'h0BADF00D;
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_we_n", 64'(sram_we_n), 64'd1);
        checkOutput("abort_ready", 64'(bus.ready), 64'd1);
        checkOutput("abort_read_data", 64'(bus.read_data), 64'd0);
        @(negedge clk);
        checkOutput("abort_dq_released", sram_dq, model_pair);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, 17'd0, 32'h11111111, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("bus_contention_cycles", 64'(contention), 64'd0);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit in case the design never returns to ready
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: actual=running required=finished");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
